// File: rtl/sap_controller_pkg.sv
// SAP-1 controller shared constants: opcodes, ring states, control-word bits.
// Imported by the controller, the ring counter and the datapath top level.
package sap_controller_pkg;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T2 = 6'b000010;
  localparam logic [5:0] T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000;
  localparam logic [5:0] T5 = 6'b010000;
  localparam logic [5:0] T6 = 6'b100000;

  localparam int CW_W  = 12;
  localparam int CW_CP = 11;
  localparam int CW_EP = 10;
  localparam int CW_LM = 9;
  localparam int CW_CE = 8;
  localparam int CW_LI = 7;
  localparam int CW_EI = 6;
  localparam int CW_LA = 5;
  localparam int CW_EA = 4;
  localparam int CW_SU = 3;
  localparam int CW_EU = 2;
  localparam int CW_LB = 1;
  localparam int CW_LO = 0;

  typedef logic [CW_W-1:0] cw_t;

endpackage

// File: rtl/sap_controller_ring_counter.sv
// Six-state one-hot ring counter T1..T6 for the SAP-1 sequencer.
// cls reloads T1; en gates the rotation.
module ring_counter
  import sap_controller_pkg::*;
(
  input  logic       clk,
  input  logic       cls,
  input  logic       en,
  output logic [5:0] t_state
);

  always_ff @(posedge clk) begin
    if (cls) begin
      t_state <= T1;
    end else if (en) begin
      t_state <= {t_state[4:0], t_state[5]};
    end
  end

endmodule

// File: rtl/sap_controller.sv
// SAP-1 controller-sequencer: ring counter, sticky halt flag and
// Moore control-word decode over t_state and opcode.
module sap_controller
  import sap_controller_pkg::*;
(
  input  logic       clk,
  input  logic       cls,
  input  logic       prog_run,
  input  logic [3:0] opcode,
  output logic [5:0] t_state,
  output logic       cp,
  output logic       ep,
  output logic       lm,
  output logic       ce,
  output logic       li,
  output logic       ei,
  output logic       la,
  output logic       ea,
  output logic       su,
  output logic       eu,
  output logic       lb,
  output logic       lo,
  output logic       hlt
);

  logic ring_clr;
  logic ring_en;
  cw_t  cw;

  // Program mode parks the ring at T1 so run mode always starts a fresh fetch.
  assign ring_clr = cls | ~prog_run;
  assign ring_en  = prog_run & ~hlt;

  ring_counter u_ring (
    .clk     (clk),
    .cls     (ring_clr),
    .en      (ring_en),
    .t_state (t_state)
  );

  always_ff @(posedge clk) begin
    if (cls) begin
      hlt <= 1'b0;
    end else if (prog_run && t_state == T4 && opcode == OP_HLT) begin
      hlt <= 1'b1;
    end
  end

  always_comb begin
    cw = '0;
    unique case (1'b1)
      t_state == T1: begin
        cw[CW_EP] = 1'b1;
        cw[CW_LM] = 1'b1;
      end
      t_state == T2: cw[CW_CP] = 1'b1;
      t_state == T3: begin
        cw[CW_CE] = 1'b1;
        cw[CW_LI] = 1'b1;
      end
      t_state == T4: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB: begin
            cw[CW_EI] = 1'b1;
            cw[CW_LM] = 1'b1;
          end
          OP_OUT: begin
            cw[CW_EA] = 1'b1;
            cw[CW_LO] = 1'b1;
          end
          default: ;
        endcase
      end
      t_state == T5: begin
        case (opcode)
          OP_LDA: begin
            cw[CW_CE] = 1'b1;
            cw[CW_LA] = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            cw[CW_CE] = 1'b1;
            cw[CW_LB] = 1'b1;
          end
          default: ;
        endcase
      end
      t_state == T6: begin
        case (opcode)
          OP_ADD: begin
            cw[CW_EU] = 1'b1;
            cw[CW_LA] = 1'b1;
          end
          OP_SUB: begin
            cw[CW_EU] = 1'b1;
            cw[CW_SU] = 1'b1;
            cw[CW_LA] = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
    if (cls || !prog_run || hlt) begin
      cw = '0;
    end
  end

  assign cp = cw[CW_CP];
  assign ep = cw[CW_EP];
  assign lm = cw[CW_LM];
  assign ce = cw[CW_CE];
  assign li = cw[CW_LI];
  assign ei = cw[CW_EI];
  assign la = cw[CW_LA];
  assign ea = cw[CW_EA];
  assign su = cw[CW_SU];
  assign eu = cw[CW_EU];
  assign lb = cw[CW_LB];
  assign lo = cw[CW_LO];

endmodule

// File: tb/tb_sap_controller.sv
// Scoreboard bench for sap_controller: a phase/halt model queues the
// expected ring state, halt flag and control word for every cycle.
module tb_sap_controller;

  logic       clk;
  logic       cls;
  logic       prog_run;
  logic [3:0] opcode;
  logic [5:0] t_state;
  logic       cp, ep, lm, ce, li, ei;
  logic       la, ea, su, eu, lb, lo;
  logic       hlt;

  sap_controller dut (
    .clk      (clk),
    .cls      (cls),
    .prog_run (prog_run),
    .opcode   (opcode),
    .t_state  (t_state),
    .cp       (cp),
    .ep       (ep),
    .lm       (lm),
    .ce       (ce),
    .li       (li),
    .ei       (ei),
    .la       (la),
    .ea       (ea),
    .su       (su),
    .eu       (eu),
    .lb       (lb),
    .lo       (lo),
    .hlt      (hlt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // bench order: {cp,ep,lm,ce,li,ei,la,ea,su,eu,lb,lo}
  localparam logic [11:0] B_CP = 12'h800;
  localparam logic [11:0] B_EP = 12'h400;
  localparam logic [11:0] B_LM = 12'h200;
  localparam logic [11:0] B_CE = 12'h100;
  localparam logic [11:0] B_LI = 12'h080;
  localparam logic [11:0] B_EI = 12'h040;
  localparam logic [11:0] B_LA = 12'h020;
  localparam logic [11:0] B_EA = 12'h010;
  localparam logic [11:0] B_SU = 12'h008;
  localparam logic [11:0] B_EU = 12'h004;
  localparam logic [11:0] B_LB = 12'h002;
  localparam logic [11:0] B_LO = 12'h001;

  typedef struct {
    logic        ts_known;
    logic [5:0]  ts;
    logic        h;
    logic [11:0] cw;
  } exp_t;

  exp_t exp_q[$];

  int n_tests;
  int n_fail;
  int ph;
  logic halted;
  logic known;

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [11:0] ref_cw(input int p, input logic [3:0] op);
    logic [11:0] w;
    w = 12'h000;
    case (p)
      0: w = B_EP | B_LM;
      1: w = B_CP;
      2: w = B_CE | B_LI;
      3: begin
        if (op == 4'h0 || op == 4'h1 || op == 4'h2) w = B_EI | B_LM;
        else if (op == 4'hE) w = B_EA | B_LO;
      end
      4: begin
        if (op == 4'h0) w = B_CE | B_LA;
        else if (op == 4'h1 || op == 4'h2) w = B_CE | B_LB;
      end
      5: begin
        if (op == 4'h1) w = B_EU | B_LA;
        else if (op == 4'h2) w = B_EU | B_SU | B_LA;
      end
      default: w = 12'h000;
    endcase
    return w;
  endfunction

  // One clock: drive on the falling edge, queue expectations, check, then
  // advance the model at the rising edge.
  task automatic cyc(input logic c, input logic r, input logic [3:0] op);
    exp_t e;
    exp_t g;
    @(negedge clk);
    cls      = c;
    prog_run = r;
    opcode   = op;
    e.ts_known = known;
    e.ts = 6'(1 << ph);
    e.h  = halted;
    e.cw = (c || !r || halted) ? 12'h000 : ref_cw(ph, op);
    exp_q.push_back(e);
    #1;
    g = exp_q.pop_front();
    if (g.ts_known) begin
      check("t_state", {10'd0, t_state}, {10'd0, g.ts});
      check("hlt", {15'd0, hlt}, {15'd0, g.h});
    end
    check("ctrl", {4'd0, cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo},
          {4'd0, g.cw});
    @(posedge clk);
    if (c) begin
      ph = 0;
      halted = 1'b0;
      known = 1'b1;
    end else if (!r) begin
      ph = 0;
    end else if (!halted) begin
      if (ph == 3 && op == 4'hF) halted = 1'b1;
      ph = (ph + 1) % 6;
    end
  endtask

  task automatic instr(input logic [3:0] op);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, op);
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    ph = 0;
    halted = 1'b0;
    known = 1'b0;
    cls = 1'b1;
    prog_run = 1'b0;
    opcode = 4'h0;

    cyc(1'b1, 1'b1, 4'h0);
    cyc(1'b1, 1'b1, 4'h0);
    instr(4'h0);
    instr(4'h1);
    instr(4'h2);
    instr(4'h7);
    instr(4'hE);

    // mode switch during T3
    cyc(1'b0, 1'b1, 4'h0);
    cyc(1'b0, 1'b1, 4'h0);
    cyc(1'b0, 1'b0, 4'h0);
    cyc(1'b0, 1'b0, 4'h0);
    instr(4'h0);

    // reset during T5 of ADD
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 4'h1);
    cyc(1'b1, 1'b1, 4'h1);
    instr(4'h1);

    // halt, hold, mode toggle, then clear by reset
    instr(4'hF);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 4'hF);
    cyc(1'b0, 1'b0, 4'hF);
    cyc(1'b0, 1'b0, 4'hF);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 4'hF);
    cyc(1'b1, 1'b1, 4'hF);
    instr(4'h2);
    cyc(1'b0, 1'b1, 4'h0);

    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard residue got=%0d want=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
